systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 17 +
 rtl/systolic_feeder_skew_lane.sv | 39 +++
 rtl/systolic_feeder.sv | 133 +++++++++++++
 tb/tb_systolic_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder and the array PEs: FSM state encoding
// and default word/index widths.
package systolic_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } feeder_state_e;

    localparam int DEFAULT_BIT_RES        = 32;
    localparam int DEFAULT_INDEX_BIT_SIZE = 16;
    localparam int FRAC_BITS              = 16;

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One zero-fill delay line of DEPTH registers; a lane of depth d presents din
// exactly d cycles after it was sampled.
module skew_lane
    import systolic_feeder_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = DEFAULT_BIT_RES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews accepted vectors onto the systolic array edge (lane i delayed i+1 cycles).
// Optional bubble counter output stall_cnt when SYSTOLIC_FEEDER_STALL_CNT_EN is defined.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int N              = 4,
    parameter int bit_res        = DEFAULT_BIT_RES,
    parameter int index_bit_size = DEFAULT_INDEX_BIT_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [index_bit_size-1:0]     k_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [N*bit_res-1:0]   in_vec,
    output logic signed [N*bit_res-1:0]   lane_out,
    output logic                          array_clr,
    output logic                          busy,
    output logic                          done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    output logic [index_bit_size-1:0]     stall_cnt
`endif
);

    // Zero tail long enough for the last element to cross the whole array.
    localparam int FLUSH_LEN = 2 * N - 2;
    localparam logic [index_bit_size-1:0] ONE = index_bit_size'(1);
    localparam logic [index_bit_size-1:0] FLUSH_LAST =
        index_bit_size'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

    feeder_state_e               state_q, state_d;
    logic [index_bit_size-1:0]   k_len_q, k_len_d;
    logic [index_bit_size-1:0]   acc_cnt_q, acc_cnt_d;
    logic [index_bit_size-1:0]   flush_cnt_q, flush_cnt_d;
    logic                        handshake;
    logic [N*bit_res-1:0]        lane_in;

    assign in_ready  = (state_q == ST_STREAM);
    assign handshake = in_ready & in_valid;
    assign array_clr = (state_q == ST_CLEAR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    // Non-handshake cycles push zeros so every lane stays on the same diagonal.
    assign lane_in   = handshake ? in_vec : '0;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        acc_cnt_d   = acc_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    state_d = (k_len == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_cnt_d   = '0;
                flush_cnt_d = '0;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (handshake) begin
                    acc_cnt_d = acc_cnt_q + ONE;
                    if (acc_cnt_d == k_len_q) begin
                        state_d = (FLUSH_LEN == 0) ? ST_DONE : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + ONE;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            acc_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            acc_cnt_q   <= acc_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(
            .DEPTH (i + 1),
            .WIDTH (bit_res)
        ) u_skew_lane (
            .clk   (clk),
            .reset (reset),
            .din   (lane_in[i*bit_res +: bit_res]),
            .dout  (lane_out[i*bit_res +: bit_res])
        );
    end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    logic [index_bit_size-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_CLEAR) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_STREAM) && !in_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and randomized jobs for systolic_feeder checked every cycle against a
// job-level timing model and a queue of injected vectors.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 16;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [IW-1:0] k_len;
  logic [VW-1:0] in_vec, lane_out;
  logic          in_ready, array_clr, busy, done;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [IW-1:0] stall_cnt;
`endif

  systolic_feeder #(.N(N), .bit_res(W), .index_bit_size(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .lane_out  (lane_out),
    .array_clr (array_clr),
    .busy      (busy),
    .done      (done)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // job-level reference model
  bit            m_job = 1'b0;
  int            m_s = 0, m_k = 0, m_acc = 0, m_done_at = -1, m_last_hs = -1;
  logic [IW-1:0] m_stall = '0;
  logic [VW-1:0] exp_q[$];        // exp_q[j] = vector injected j+1 cycles ago
  logic [VW-1:0] src_q[$];
  logic [VW-1:0] lane_log [0:4095];

  int obs_done_cnt, obs_done_cyc, obs_hs_cnt, job_first_hs, job_start_cyc;
  bit obs_clr_seen, obs_ready_seen;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_of(input logic [VW-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  function automatic bit exp_ready_now();
    return m_job && (m_k != 0) && (cyc >= m_s + 2) && (m_acc < m_k);
  endfunction

  // check the current cycle, then advance the model across the next rising edge
  task automatic run_cycle(output bit hs);
    bit e_busy, e_clr, e_ready, e_done;
    logic [VW-1:0] e_lane;
    e_busy  = m_job;
    e_clr   = m_job && (m_k != 0) && (cyc == m_s + 1);
    e_ready = exp_ready_now();
    e_done  = m_job && (cyc == m_done_at);
    for (int i = 0; i < N; i++) e_lane[i*W +: W] = lane_of(exp_q[i], i);
    chk("lane_out", lane_out, e_lane);
    chk("in_ready", VW'(in_ready), VW'(e_ready));
    chk("busy", VW'(busy), VW'(e_busy));
    chk("array_clr", VW'(array_clr), VW'(e_clr));
    chk("done", VW'(done), VW'(e_done));
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("stall_cnt", VW'(stall_cnt), VW'(m_stall));
`endif
    if (cyc < 4096) lane_log[cyc] = lane_out;
    if (done === 1'b1) begin obs_done_cnt++; obs_done_cyc = cyc; end
    if (in_ready === 1'b1 && in_valid) obs_hs_cnt++;
    if (array_clr === 1'b1) obs_clr_seen = 1'b1;
    if (in_ready === 1'b1) obs_ready_seen = 1'b1;

    hs = !reset && in_valid && e_ready;
    if (reset) begin
      m_job = 1'b0; m_stall = '0; m_done_at = -1;
      for (int i = 0; i < N; i++) exp_q[i] = '0;
    end else begin
      exp_q.push_front(hs ? in_vec : '0);
      void'(exp_q.pop_back());
      if (e_clr) m_stall = '0;
      else if (e_ready && !in_valid && m_stall != '1) m_stall = m_stall + 1'b1;
      if (hs) begin
        m_acc++;
        if (m_acc == m_k) begin m_last_hs = cyc; m_done_at = cyc + 2 * N - 1; end
      end
      if (e_done) m_job = 1'b0;
      if (!e_busy && start) begin
        m_job = 1'b1; m_s = cyc; m_k = int'(k_len); m_acc = 0; m_last_hs = -1;
        m_done_at = (k_len == '0) ? cyc + 1 : -1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // driver: one job from start to done (or to an abort inside FLUSH)
  task automatic drive_job(input int k, input int gap_at, input int gap_len, input int pct,
                           input bit start_mid, input bit abort_flush);
    bit hs;
    bit rdy;
    int n = 0;
    int gaps = 0;
    obs_done_cnt = 0; obs_done_cyc = -1; obs_hs_cnt = 0;
    obs_clr_seen = 1'b0; obs_ready_seen = 1'b0;
    job_first_hs = -1; job_start_cyc = cyc;
    start = 1'b1; k_len = IW'(k); in_valid = 1'b1; in_vec = rand_vec();
    run_cycle(hs);
    start = 1'b0;
    for (int g = 0; g < 500; g++) begin
      rdy = exp_ready_now();
      if (rdy && n == gap_at && gaps < gap_len) begin
        in_valid = 1'b0; gaps++;
      end else begin
        in_valid = ($urandom_range(0, 99) < pct);
      end
      in_vec = (src_q.size() > 0) ? src_q[0] : rand_vec();
      if (start_mid && rdy && n == 1) begin start = 1'b1; k_len = IW'(k + 5); end
      if (abort_flush && m_last_hs >= 0 && cyc == m_last_hs + 2) reset = 1'b1;
      run_cycle(hs);
      start = 1'b0;
      if (hs) begin
        if (job_first_hs < 0) job_first_hs = cyc - 1;
        n++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (reset) begin reset = 1'b0; return; end
      if (!m_job) return;
    end
    chk("job_timeout", VW'(m_job), VW'(0));
  endtask

  task automatic idle_cycles(input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'(($urandom & 1)); in_vec = rand_vec(); start = 1'b0;
      run_cycle(hs);
    end
  endtask

  initial begin
    bit hs;
    int k;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0; in_vec = '0;
    for (int i = 0; i < N; i++) exp_q.push_back('0);
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    in_valid = 1'b1; start = 1'b1; k_len = 16'd3;
    run_cycle(hs);
    run_cycle(hs);
    chk("reset_lane_out", lane_out, '0);
    chk("reset_busy", VW'(busy), VW'(0));
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    idle_cycles(2);

    // three back-to-back vectors
    src_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    src_q.push_back({32'd8, 32'd7, 32'd6, 32'd5});
    src_q.push_back({32'd12, 32'd11, 32'd10, 32'd9});
    drive_job(3, -1, 0, 100, 1'b0, 1'b0);
    chk("k3_lane3_at_hs+4", VW'(lane_of(lane_log[job_first_hs + 4], 3)), VW'(4));
    chk("k3_lane0_at_hs+1", VW'(lane_of(lane_log[job_first_hs + 1], 0)), VW'(1));
    chk("k3_lane2_last", VW'(lane_of(lane_log[job_first_hs + 5], 2)), VW'(11));
    // done occupies the 10th cycle counting the first handshake cycle as cycle 1
    chk("k3_done_offset", VW'(obs_done_cyc - job_first_hs), VW'(9));
    chk("k3_done_count", VW'(obs_done_cnt), VW'(1));
    idle_cycles(2);

    // same job with a two-cycle bubble after the first vector
    src_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    src_q.push_back({32'd8, 32'd7, 32'd6, 32'd5});
    src_q.push_back({32'd12, 32'd11, 32'd10, 32'd9});
    drive_job(3, 1, 2, 100, 1'b0, 1'b0);
    chk("bub_lane3_zero_a", VW'(lane_of(lane_log[job_first_hs + 5], 3)), VW'(0));
    chk("bub_lane3_zero_b", VW'(lane_of(lane_log[job_first_hs + 6], 3)), VW'(0));
    chk("bub_lane3_vec2", VW'(lane_of(lane_log[job_first_hs + 7], 3)), VW'(8));
    chk("bub_lane0_vec2", VW'(lane_of(lane_log[job_first_hs + 4], 0)), VW'(5));
    chk("bub_done_offset", VW'(obs_done_cyc - job_first_hs), VW'(11));
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("bub_stall_cnt", VW'(stall_cnt), VW'(2));
`endif
    idle_cycles(2);

    // empty job
    drive_job(0, -1, 0, 100, 1'b0, 1'b0);
    chk("k0_done_count", VW'(obs_done_cnt), VW'(1));
    chk("k0_done_offset", VW'(obs_done_cyc - job_start_cyc), VW'(1));
    chk("k0_no_clr", VW'(obs_clr_seen), VW'(0));
    chk("k0_no_ready", VW'(obs_ready_seen), VW'(0));
    idle_cycles(2);

    // reset during FLUSH, then a normal job
    drive_job(2, -1, 0, 100, 1'b0, 1'b1);
    idle_cycles(1);
    chk("abort_no_done", VW'(obs_done_cnt), VW'(0));
    chk("abort_busy", VW'(busy), VW'(0));
    chk("abort_lane_out", lane_out, '0);
    drive_job(3, -1, 0, 70, 1'b0, 1'b0);
    chk("after_abort_done", VW'(obs_done_cnt), VW'(1));
    idle_cycles(2);

    // most-negative word on lane 2
    src_q.push_back({32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
    drive_job(1, -1, 0, 100, 1'b0, 1'b0);
    chk("neg_lane2_at_hs+3", VW'(lane_of(lane_log[job_first_hs + 3], 2)), VW'(32'h8000_0000));
    idle_cycles(2);

    // start pulsed mid-stream is ignored
    drive_job(4, -1, 0, 100, 1'b1, 1'b0);
    chk("restart_hs_count", VW'(obs_hs_cnt), VW'(4));
    chk("restart_done_offset", VW'(obs_done_cyc - job_first_hs), VW'(10));
    idle_cycles(2);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      k = $urandom_range(0, 7);
      drive_job(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(30, 100),
                1'(($urandom & 1)), 1'b0);
      chk("rand_done_count", VW'(obs_done_cnt), VW'(1));
      chk("rand_hs_count", VW'(obs_hs_cnt), VW'(k));
      idle_cycles($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
